// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline sequencer states and architectural constants.
package cpu_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard observations from ID/EX/MEM and the enable/flush/bubble controls back to the pipeline.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             id_br_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_bubble;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_memread,
           id_br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en,
           memwb_bubble, state_o, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_memread,
           id_br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en,
           memwb_bubble, state_o, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; synchronous active-high clear.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use stall, ID branch flush and data-memory wait freeze,
// plus saturating stall/flush statistics and a sticky memory-timeout flag.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
);
  localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state;
  hz_state_t         nextState;
  logic              memStall;
  logic              luHazard;
  logic              luArmed;
  logic              waitClr;
  logic [WAIT_W-1:0] waitCount;
  logic [CNT_W-1:0]  stallCount;
  logic [CNT_W-1:0]  flushCount;
  logic              memTimeout;

  always_comb begin
    memStall = hz.mem_req & ~hz.mem_ready;
    luHazard = hz.ex_memread && (hz.ex_rd != REG_W'(XZR_IDX)) &&
               ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));
    // The cycle after a load-use stall the load sits in MEM and forwarding covers it.
    luArmed  = luHazard && (state != LU_STALL);
  end

  always_comb begin
    hz.pc_en        = 1'b0;
    hz.ifid_en      = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_en     = 1'b0;
    hz.memwb_en     = 1'b0;
    hz.memwb_bubble = 1'b0;
    if (!reset) begin
      if (memStall) begin
        hz.memwb_bubble = 1'b1;
      end else if (luArmed) begin
        hz.idex_bubble = 1'b1;
        hz.exmem_en    = 1'b1;
        hz.memwb_en    = 1'b1;
      end else begin
        hz.pc_en      = 1'b1;
        hz.ifid_en    = 1'b1;
        hz.exmem_en   = 1'b1;
        hz.memwb_en   = 1'b1;
        hz.ifid_flush = hz.id_br_taken;
      end
    end
  end

  always_comb begin
    nextState = RUN;
    if (memStall)
      nextState = MEM_WAIT;
    else if (luArmed)
      nextState = LU_STALL;
  end

  // Registered stage: FSM state and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      memTimeout <= 1'b0;
    end else begin
      state <= nextState;
      if (memStall && (waitCount >= TIMEOUT_M1))
        memTimeout <= 1'b1;
    end
  end

  assign waitClr = reset | ~memStall;

  sat_counter #(.WIDTH(CNT_W)) uStallCnt (
    .clk(clk), .reset(reset), .inc(~hz.pc_en), .count(stallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) uFlushCnt (
    .clk(clk), .reset(reset), .inc(hz.ifid_flush), .count(flushCount)
  );

  sat_counter #(.WIDTH(WAIT_W)) uWaitCnt (
    .clk(clk), .reset(waitClr), .inc(memStall), .count(waitCount)
  );

  assign hz.state_o     = state;
  assign hz.stall_count = stallCount;
  assign hz.flush_count = flushCount;
  assign hz.mem_timeout = memTimeout;
endmodule
